pipe_hazard_ctrl: RTL and testbench

- Hazard and sequencing controller for the 5-stage pipelined CPU (IF, ID, EX, MEM, WB).
- Tracks the destination register of each in-flight instruction in EX, MEM and WB.
- Drives PC / IF-ID enables, IF-ID flush and ID-EX bubble insertion, plus registered operand-forwarding selects for EX.
- Handles load-use stalls, taken-branch flushes and whole-pipeline freezes from the SRAM; keeps saturating stall and flush counters.

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/sat_counter.sv | 18 +
 rtl/pipe_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: decode opcodes, forwarding selects and the pipeline stage slot.
package cpu_pkg;

   localparam logic [3:0] OP_NOP   = 4'b0000;
   localparam logic [3:0] OP_ADD   = 4'b0001;
   localparam logic [3:0] OP_SUB   = 4'b0010;
   localparam logic [3:0] OP_AND   = 4'b0011;
   localparam logic [3:0] OP_ORR   = 4'b0100;
   localparam logic [3:0] OP_XOR   = 4'b0101;
   localparam logic [3:0] OP_LSL   = 4'b0110;
   localparam logic [3:0] OP_LOAD  = 4'b0111;
   localparam logic [3:0] OP_STORE = 4'b1000;
   localparam logic [3:0] OP_B     = 4'b1001;
   localparam logic [3:0] OP_BR    = 4'b1010;
   localparam logic [3:0] OP_BGT   = 4'b1011;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   localparam logic [4:0] ZERO_REG = 5'd31;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       reg_en;
      logic       is_load;
   } stage_info_t;

   // ALU ops, load, store and BR read Rn
   function automatic logic uses_rn(input logic [3:0] op);
      return ((op >= OP_ADD) && (op <= OP_STORE)) || (op == OP_BR);
   endfunction

   // LSL takes a shift immediate, so only the two-operand ALU ops read Rm
   function automatic logic uses_rm(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_XOR);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (inc && (cnt != {CNT_W{1'b1}}))
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing control for the 5-stage pipe: load-use stalls, branch flushes,
// SRAM freezes and registered EX operand-forwarding selects.
module pipe_hazard_ctrl #(
   parameter int         CNT_W    = 16,
   parameter logic [4:0] ZERO_REG = 5'd31
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [3:0]       id_op,
   input  logic [4:0]       id_Rn,
   input  logic [4:0]       id_Rm,
   input  logic [4:0]       id_Rd,
   input  logic             id_reg_en,
   input  logic             ex_branch_taken,
   input  logic             mem_busy,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   import cpu_pkg::*;

   stage_info_t ex_s, mem_s, wb_s;
   logic        use_a, use_b, load_use, advance;
   logic        stall_inc, flush_inc;
   logic [1:0]  fwd_a_nxt, fwd_b_nxt;

   function automatic logic slot_match(input stage_info_t s, input logic [4:0] src);
      return s.valid && s.reg_en && (s.rd != ZERO_REG) && (s.rd == src);
   endfunction

   // EX slot is the newest producer, so it is checked first
   function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] src,
                                          input stage_info_t ex, input stage_info_t mem);
      if (used && slot_match(ex, src))
         return FWD_EXMEM;
      else if (used && slot_match(mem, src))
         return FWD_MEMWB;
      else
         return FWD_RF;
   endfunction

   assign use_a    = uses_rn(id_op);
   assign use_b    = uses_rm(id_op);
   assign load_use = id_valid && ex_s.is_load &&
                     ((use_a && slot_match(ex_s, id_Rn)) || (use_b && slot_match(ex_s, id_Rm)));
   assign advance  = !mem_busy && !ex_branch_taken && !load_use;

   assign fwd_a_nxt = id_valid ? fwd_sel(use_a, id_Rn, ex_s, mem_s) : FWD_RF;
   assign fwd_b_nxt = id_valid ? fwd_sel(use_b, id_Rm, ex_s, mem_s) : FWD_RF;

   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      if (rst) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (mem_busy) begin
         pc_en   = 1'b0;
         ifid_en = 1'b0;
      end else if (ex_branch_taken) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (load_use) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_bubble = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_s  <= '0;
         mem_s <= '0;
         wb_s  <= '0;
         fwd_a <= FWD_RF;
         fwd_b <= FWD_RF;
      end else if (!mem_busy) begin
         wb_s  <= mem_s;
         mem_s <= ex_s;
         if (advance) begin
            ex_s  <= '{valid: id_valid, rd: id_Rd, reg_en: id_reg_en, is_load: (id_op == OP_LOAD)};
            fwd_a <= fwd_a_nxt;
            fwd_b <= fwd_b_nxt;
         end else begin
            ex_s  <= '0;
            fwd_a <= FWD_RF;
            fwd_b <= FWD_RF;
         end
      end
   end

   assign stall_inc = !mem_busy && !ex_branch_taken && load_use;
   assign flush_inc = !mem_busy && ex_branch_taken;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (stall_inc),
      .cnt (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .inc (flush_inc),
      .cnt (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; a 2-bit-counter copy shares the stimulus to hit saturation.
module tb_pipe_hazard_ctrl;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_valid = 1'b0, id_reg_en = 1'b0, ex_branch_taken = 1'b0, mem_busy = 1'b0;
   logic [3:0]  id_op = OP_NOP;
   logic [4:0]  id_Rn = '0, id_Rm = '0, id_Rd = '0;

   logic        pc_en, ifid_en, ifid_flush, idex_bubble;
   logic [1:0]  fwd_a, fwd_b;
   logic [15:0] stall_cnt, flush_cnt;
   logic        pc_en2, ifid_en2, ifid_flush2, idex_bubble2;
   logic [1:0]  fwd_a2, fwd_b2;
   logic [1:0]  stall_cnt2, flush_cnt2;

   int checks = 0;
   int errors = 0;
   int mdl_stall = 0;
   int mdl_flush = 0;
   logic [3:0] fwd_q[$];

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_Rn(id_Rn), .id_Rm(id_Rm),
      .id_Rd(id_Rd), .id_reg_en(id_reg_en), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipe_hazard_ctrl #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_Rn(id_Rn), .id_Rm(id_Rm),
      .id_Rd(id_Rd), .id_reg_en(id_reg_en), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
      .pc_en(pc_en2), .ifid_en(ifid_en2), .ifid_flush(ifid_flush2), .idex_bubble(idex_bubble2),
      .fwd_a(fwd_a2), .fwd_b(fwd_b2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_cnts(input string tag);
      chk({tag, " stall_cnt"},  32'(stall_cnt),  32'(mdl_stall > 65535 ? 65535 : mdl_stall));
      chk({tag, " flush_cnt"},  32'(flush_cnt),  32'(mdl_flush > 65535 ? 65535 : mdl_flush));
      chk({tag, " stall_cnt2"}, 32'(stall_cnt2), 32'(mdl_stall > 3 ? 3 : mdl_stall));
      chk({tag, " flush_cnt2"}, 32'(flush_cnt2), 32'(mdl_flush > 3 ? 3 : mdl_flush));
   endtask

   // Drive one ID cycle, check combinational controls mid-cycle, then the
   // registered selects (queued at drive time) and counters after the edge.
   task automatic step(input string tag, input logic v, input logic [3:0] op,
                       input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                       input logic re, input logic br, input logic busy,
                       input logic e_pc, input logic e_ifid, input logic e_fl, input logic e_bub,
                       input logic [1:0] e_fa, input logic [1:0] e_fb);
      logic [3:0] exp_fwd;
      id_valid = v; id_op = op; id_Rn = rn; id_Rm = rm; id_Rd = rd; id_reg_en = re;
      ex_branch_taken = br; mem_busy = busy;
      fwd_q.push_back({e_fa, e_fb});
      #4;
      chk({tag, " pc_en"},       32'(pc_en),       32'(e_pc));
      chk({tag, " ifid_en"},     32'(ifid_en),     32'(e_ifid));
      chk({tag, " ifid_flush"},  32'(ifid_flush),  32'(e_fl));
      chk({tag, " idex_bubble"}, 32'(idex_bubble), 32'(e_bub));
      @(posedge clk);
      if (!busy) begin
         if (br) mdl_flush++;
         else if (e_bub) mdl_stall++;
      end
      #1;
      exp_fwd = fwd_q.pop_front();
      chk({tag, " fwd_a"}, 32'(fwd_a), 32'(exp_fwd[3:2]));
      chk({tag, " fwd_b"}, 32'(fwd_b), 32'(exp_fwd[1:0]));
      chk_cnts(tag);
   endtask

   initial begin
      // power-on reset
      repeat (2) @(posedge clk);
      #1;
      chk("rst pc_en",       32'(pc_en),       32'd0);
      chk("rst ifid_en",     32'(ifid_en),     32'd0);
      chk("rst ifid_flush",  32'(ifid_flush),  32'd1);
      chk("rst idex_bubble", 32'(idex_bubble), 32'd1);
      chk("rst fwd_a", 32'(fwd_a), 32'd0);
      chk("rst fwd_b", 32'(fwd_b), 32'd0);
      chk_cnts("rst");
      rst = 1'b0;

      //     tag        v  op        rn  rm  rd re br bz  pc if fl bb  fa     fb
      // load-use: LD r3 then ADD r3,r4
      step("lu ld",    1, OP_LOAD,  1,  0,  3, 1, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);
      step("lu stall", 1, OP_ADD,   3,  4,  8, 1, 0, 0,  0, 0, 0, 1, 2'b00, 2'b00);
      step("lu go",    1, OP_ADD,   3,  4,  8, 1, 0, 0,  1, 1, 0, 0, 2'b10, 2'b00);
      // double forward, newest producer wins
      step("df add",   1, OP_ADD,   1,  2,  5, 1, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);
      step("df sub",   1, OP_SUB,   1,  2,  5, 1, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);
      step("df orr",   1, OP_ORR,   5,  5,  6, 1, 0, 0,  1, 1, 0, 0, 2'b01, 2'b01);
      // ZERO_REG and source usage
      step("zr ld31",  1, OP_LOAD,  1,  0, 31, 1, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);
      step("zr add31", 1, OP_ADD,  31, 31,  9, 1, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);
      step("su ld7",   1, OP_LOAD,  2,  0,  7, 1, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);
      step("su lsl",   1, OP_LSL,   2,  7, 10, 1, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);
      step("su ld7b",  1, OP_LOAD,  2,  0,  7, 1, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);
      step("su stall", 1, OP_ADD,   2,  7, 11, 1, 0, 0,  0, 0, 0, 1, 2'b00, 2'b00);
      step("su go",    1, OP_ADD,   2,  7, 11, 1, 0, 0,  1, 1, 0, 0, 2'b00, 2'b10);
      // taken branch beats load-use
      step("br ld",    1, OP_LOAD,  1,  0,  4, 1, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);
      step("br flush", 1, OP_ADD,   4,  1, 12, 1, 1, 0,  1, 1, 1, 1, 2'b00, 2'b00);
      step("br nop",   0, OP_NOP,   0,  0,  0, 0, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);
      // freeze during a load-use hazard, with a non-zero select held
      step("fz add",   1, OP_ADD,   1,  1, 14, 1, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);
      step("fz ld",    1, OP_LOAD, 14,  0,  6, 1, 0, 0,  1, 1, 0, 0, 2'b01, 2'b00);
      for (int i = 0; i < 3; i++)
         step("fz busy", 1, OP_ADD, 6,  6, 13, 1, 0, 1,  0, 0, 0, 0, 2'b01, 2'b00);
      step("fz stall", 1, OP_ADD,   6,  6, 13, 1, 0, 0,  0, 0, 0, 1, 2'b00, 2'b00);
      step("fz go",    1, OP_ADD,   6,  6, 13, 1, 0, 0,  1, 1, 0, 0, 2'b10, 2'b10);
      // flush counter saturation on the 2-bit copy
      for (int i = 0; i < 5; i++)
         step("sat br",  0, OP_NOP,  0,  0,  0, 0, 1, 0,  1, 1, 1, 1, 2'b00, 2'b00);
      chk("sat flush_cnt2 final", 32'(flush_cnt2), 32'd3);
      chk("sat flush_cnt final",  32'(flush_cnt),  32'd6);

      // reset mid-stream with a load tracked in EX and a dependent op in ID
      step("mr ld",    1, OP_LOAD,  1,  0,  3, 1, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);
      id_valid = 1; id_op = OP_ADD; id_Rn = 3; id_Rm = 4; id_Rd = 9; id_reg_en = 1;
      rst = 1'b1;
      #4;
      chk("mr pc_en",       32'(pc_en),       32'd0);
      chk("mr ifid_flush",  32'(ifid_flush),  32'd1);
      chk("mr idex_bubble", 32'(idex_bubble), 32'd1);
      @(posedge clk);
      #1;
      mdl_stall = 0;
      mdl_flush = 0;
      chk("mr fwd_a", 32'(fwd_a), 32'd0);
      chk("mr fwd_b", 32'(fwd_b), 32'd0);
      chk_cnts("mr");
      rst = 1'b0;
      step("mr go",    1, OP_ADD,   3,  4,  9, 1, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
